// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of the MIPS instruction encoder.
// Pure wiring, no latency.
// in_valid/in_ready on the request side; mem_we held until mem_ack on the write side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [25:0] imm;
  logic        base_load;
  logic [31:0] base_addr;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        err;
  logic [15:0] count;

  // Stimulus / requester side
  modport master (
    output in_valid, op, rs, rt, rd, imm, base_load, base_addr, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_data, err, count
  );

  // Encoder side
  modport slave (
    input  in_valid, op, rs, rt, rd, imm, base_load, base_addr, mem_ack,
    output in_ready, mem_we, mem_addr, mem_data, err, count
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes MIPS mnemonics into 32-bit words, queues them, writes them to instruction memory.
// Latency: request accepted at edge N -> mem_we from edge N+1; back-to-back writes without bubbles.
// Backpressure: in_ready drops when the FIFO is full; writes hold stable until mem_ack.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  instr_encoder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state;
  logic [31:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] rd_nxt;
  logic [AW:0] occ;
  logic        full;
  logic        empty;
  logic        more;
  logic        legal;
  logic        enq;
  logic        pop;
  logic [31:0] enc_word;
  logic [31:0] addr_cnt;
  logic [31:0] addr_nxt;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic        mem_we_q;
  logic        err_q;
  logic [15:0] count_q;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign occ      = wr_ptr - rd_ptr;
  assign full     = (occ == FULL_OCC);
  assign empty    = (occ == '0);
  assign more     = (occ > PTR_ONE);
  assign rd_nxt   = rd_ptr + PTR_ONE;
  assign addr_nxt = addr_cnt + 32'd4;
  assign legal    = (bus.op <= 4'd9);
  // in_ready depends only on occupancy, never on a same-cycle pop.
  assign enq      = bus.in_valid & ~full & legal;
  assign pop      = (state == WRITE) & bus.mem_ack;

  assign bus.in_ready = ~full;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.err      = err_q;
  assign bus.count    = count_q;

  // Build the instruction word; fields an encoding does not use are forced to zero.
  always_comb begin
    enc_word = 32'd0;
    case (bus.op)
      4'd0: enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100000};
      4'd1: enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100001};
      4'd2: enc_word = {6'b001000, bus.rs, bus.rt, bus.imm[15:0]};
      4'd3: enc_word = {6'b001001, bus.rs, bus.rt, bus.imm[15:0]};
      4'd4: enc_word = {6'b100011, bus.rs, bus.rt, bus.imm[15:0]};
      4'd5: enc_word = {6'b101011, bus.rs, bus.rt, bus.imm[15:0]};
      4'd6: enc_word = {6'b000100, bus.rs, bus.rt, bus.imm[15:0]};
      4'd7: enc_word = {6'b000010, bus.imm};
      4'd8: enc_word = {6'b000011, bus.imm};
      4'd9: enc_word = {6'b000000, bus.rs, 15'd0, 6'b001000};
      default: enc_word = 32'd0;
    endcase
  end

  // FIFO storage; stale entries are harmless because the pointers reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_mem[wr_ptr[AW-1:0]] <= enc_word;
    end
  end

  // FIFO pointers; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Write FSM with registered memory outputs, address counter, write count and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_data_q <= 32'd0;
      addr_cnt   <= 32'd0;
      count_q    <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      err_q <= bus.in_valid & ~full & ~legal;
      case (state)
        IDLE: begin
          if (!empty) begin
            state      <= WRITE;
            mem_we_q   <= 1'b1;
            mem_addr_q <= addr_cnt;
            mem_data_q <= fifo_mem[rd_ptr[AW-1:0]];
          end else if (bus.base_load) begin
            // A request accepted this same edge is written at the new base.
            addr_cnt <= bus.base_addr;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            addr_cnt <= addr_nxt;
            count_q  <= count_q + 16'd1;
            if (more) begin
              mem_addr_q <= addr_nxt;
              mem_data_q <= fifo_mem[rd_nxt[AW-1:0]];
            end else begin
              state    <= IDLE;
              mem_we_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
